// File: rtl/fifo_sync_mc.sv
// Multi-channel synchronous FIFO: C independent queues of N x W bits in one shared array.
// Optional sticky overflow/underflow flags are built when FIFO_SYNC_MC_ERR_EN is defined.
module fifo_sync_mc #(
    parameter  int W  = 32,
    parameter  int N  = 32,
    parameter  int C  = 4,
    localparam int CW = (C > 1) ? $clog2(C) : 1,
    localparam int AW = $clog2(N),
    localparam int LW = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [CW-1:0]   push_chan,
    input  logic [W-1:0]    push_data,
    input  logic            pop,
    input  logic [CW-1:0]   pop_chan,
    output logic [W-1:0]    pop_data_r,
    output logic            pop_vld_r,
    output logic [C-1:0]    empty_r,
    output logic [C-1:0]    full_r,
    output logic [C*LW-1:0] level_r,
    output logic [C-1:0]    err_ovf_r,
    output logic [C-1:0]    err_udf_r
);

    // Handshake: push/pop are one-cycle requests with no ready output. A push is taken
    // when the addressed channel's registered full flag is clear, a pop when its registered
    // empty flag is clear; anything else is silently dropped. pop_vld_r follows a taken pop by one edge.

    logic [W-1:0]     r_mem [C*N];
    logic [AW:0]      r_wptr [C];
    logic [AW:0]      r_rptr [C];
    logic [LW-1:0]    r_level [C];

    logic [AW:0]      w_wptr_sel;
    logic [AW:0]      w_rptr_sel;
    logic             w_full_sel;
    logic             w_empty_sel;
    logic             w_acc_push;
    logic             w_acc_pop;
    logic [C-1:0]     w_push_hit;
    logic [C-1:0]     w_pop_hit;
    logic [LW-1:0]    w_lvl_nxt [C];
    logic [CW+AW-1:0] w_waddr;
    logic [CW+AW-1:0] w_raddr;

    // Unmatched channel numbers leave the selected flag at 1, so out-of-range requests drop.
    always_comb begin
        w_wptr_sel  = '0;
        w_rptr_sel  = '0;
        w_full_sel  = 1'b1;
        w_empty_sel = 1'b1;
        for (int k = 0; k < C; k++) begin
            if (push_chan == CW'(k)) begin
                w_wptr_sel = r_wptr[k];
                w_full_sel = full_r[k];
            end
            if (pop_chan == CW'(k)) begin
                w_rptr_sel  = r_rptr[k];
                w_empty_sel = empty_r[k];
            end
        end
    end

    assign w_acc_push = push & ~w_full_sel;
    assign w_acc_pop  = pop & ~w_empty_sel;
    assign w_waddr    = {push_chan, w_wptr_sel[AW-1:0]};
    assign w_raddr    = {pop_chan, w_rptr_sel[AW-1:0]};

    always_comb begin
        for (int k = 0; k < C; k++) begin
            w_push_hit[k] = w_acc_push && (push_chan == CW'(k));
            w_pop_hit[k]  = w_acc_pop && (pop_chan == CW'(k));
            w_lvl_nxt[k]  = r_level[k] + LW'(w_push_hit[k]) - LW'(w_pop_hit[k]);
        end
    end

    always_comb begin
        level_r = '0;
        for (int k = 0; k < C; k++) begin
            level_r[k*LW +: LW] = r_level[k];
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && w_acc_push) begin
            r_mem[w_waddr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data_r <= '0;
            pop_vld_r  <= 1'b0;
            empty_r    <= '1;
            full_r     <= '0;
            for (int k = 0; k < C; k++) begin
                r_wptr[k]  <= '0;
                r_rptr[k]  <= '0;
                r_level[k] <= '0;
            end
        end else begin
            pop_vld_r <= w_acc_pop;
            if (w_acc_pop) begin
                pop_data_r <= r_mem[w_raddr];
            end
            for (int k = 0; k < C; k++) begin
                if (w_push_hit[k]) begin
                    r_wptr[k] <= r_wptr[k] + 1'b1;
                end
                if (w_pop_hit[k]) begin
                    r_rptr[k] <= r_rptr[k] + 1'b1;
                end
                r_level[k] <= w_lvl_nxt[k];
                empty_r[k] <= (w_lvl_nxt[k] == '0);
                full_r[k]  <= (w_lvl_nxt[k] == LW'(N));
            end
        end
    end

`ifdef FIFO_SYNC_MC_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_r <= '0;
            err_udf_r <= '0;
        end else begin
            for (int k = 0; k < C; k++) begin
                if (push && (push_chan == CW'(k)) && full_r[k]) begin
                    err_ovf_r[k] <= 1'b1;
                end
                if (pop && (pop_chan == CW'(k)) && empty_r[k]) begin
                    err_udf_r[k] <= 1'b1;
                end
            end
        end
    end
`else
    assign err_ovf_r = '0;
    assign err_udf_r = '0;
`endif

endmodule

// File: tb/tb_fifo_sync_mc.sv
// Directed bench for fifo_sync_mc (C=4, N=8, W=32) with hand-computed expectations.
module tb_fifo_sync_mc;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int C  = 4;
    localparam int CW = 2;
    localparam int LW = 4;

`ifdef FIFO_SYNC_MC_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            push;
    logic [CW-1:0]   push_chan;
    logic [W-1:0]    push_data;
    logic            pop;
    logic [CW-1:0]   pop_chan;
    logic [W-1:0]    pop_data_r;
    logic            pop_vld_r;
    logic [C-1:0]    empty_r;
    logic [C-1:0]    full_r;
    logic [C*LW-1:0] level_r;
    logic [C-1:0]    err_ovf_r;
    logic [C-1:0]    err_udf_r;

    int n_vec;
    int n_mis;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_d;

    fifo_sync_mc #(.W(W), .N(N), .C(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_chan  (push_chan),
        .push_data  (push_data),
        .pop        (pop),
        .pop_chan   (pop_chan),
        .pop_data_r (pop_data_r),
        .pop_vld_r  (pop_vld_r),
        .empty_r    (empty_r),
        .full_r     (full_r),
        .level_r    (level_r),
        .err_ovf_r  (err_ovf_r),
        .err_udf_r  (err_udf_r)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_push(input logic [CW-1:0] ch, input logic [W-1:0] d);
        push = 1'b1; push_chan = ch; push_data = d;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop(input logic [CW-1:0] ch);
        pop = 1'b1; pop_chan = ch;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_mis = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0;
        push_chan = '0; pop_chan = '0; push_data = '0;

        // Reset then idle
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_empty", 64'(empty_r), 64'hF);
        chk("rst_full", 64'(full_r), 64'h0);
        chk("rst_level", 64'(level_r), 64'h0);
        chk("rst_vld", 64'(pop_vld_r), 64'h0);
        chk("rst_data", 64'(pop_data_r), 64'h0);
        chk("rst_err", 64'({err_ovf_r, err_udf_r}), 64'h0);

        // Fill chan 2 with 0x100..0x107
        for (int i = 0; i < 8; i++) begin
            do_push(2'd2, 32'h100 + 32'(i));
            exp_q.push_back(32'h100 + 32'(i));
            if (i == 6) begin
                chk("c2_full_at7", 64'(full_r), 64'h0);
                chk("c2_level7", 64'(level_r), 64'h0700);
            end
        end
        chk("c2_full_at8", 64'(full_r), 64'b0100);
        chk("c2_level8", 64'(level_r), 64'h0800);
        chk("c2_empty_at8", 64'(empty_r), 64'b1011);

        // Drain chan 2 in order
        for (int i = 0; i < 8; i++) begin
            do_pop(2'd2);
            exp_d = exp_q.pop_front();
            chk("c2_pop_vld", 64'(pop_vld_r), 64'h1);
            chk("c2_pop_data", 64'(pop_data_r), 64'(exp_d));
        end
        chk("c2_empty_after", 64'(empty_r), 64'hF);
        chk("c2_level_after", 64'(level_r), 64'h0);
        tick();
        chk("idle_vld", 64'(pop_vld_r), 64'h0);
        chk("idle_hold", 64'(pop_data_r), 64'h107);

        // Underflow: pop empty chan 2 is dropped
        do_pop(2'd2);
        chk("udf_vld", 64'(pop_vld_r), 64'h0);
        chk("udf_level", 64'(level_r), 64'h0);
        chk("udf_flag", 64'(err_udf_r), ERR_ON ? 64'b0100 : 64'h0);

        // Interleaved channels
        do_push(2'd0, 32'hA0);
        do_push(2'd3, 32'hB0);
        chk("il_level", 64'(level_r), 64'h1001);
        do_pop(2'd3);
        chk("il_pop3_vld", 64'(pop_vld_r), 64'h1);
        chk("il_pop3_data", 64'(pop_data_r), 64'hB0);
        chk("il_level_mid", 64'(level_r), 64'h0001);
        do_pop(2'd0);
        chk("il_pop0_data", 64'(pop_data_r), 64'hA0);
        chk("il_level_end", 64'(level_r), 64'h0);

        // Chan 1 full: simultaneous push+pop takes only the pop
        for (int i = 0; i < 8; i++) begin
            do_push(2'd1, 32'h10 + 32'(i));
            exp_q.push_back(32'h10 + 32'(i));
        end
        chk("c1_full", 64'(full_r), 64'b0010);
        push = 1'b1; push_chan = 2'd1; push_data = 32'hFF;
        pop  = 1'b1; pop_chan  = 2'd1;
        tick();
        push = 1'b0; pop = 1'b0;
        exp_d = exp_q.pop_front();
        chk("fpp_vld", 64'(pop_vld_r), 64'h1);
        chk("fpp_data", 64'(pop_data_r), 64'(exp_d));
        chk("fpp_level", 64'(level_r), 64'h0070);
        chk("fpp_full", 64'(full_r), 64'h0);
        chk("fpp_ovf", 64'(err_ovf_r), ERR_ON ? 64'b0010 : 64'h0);

        // Bring chan 1 to level 3
        for (int i = 0; i < 4; i++) begin
            do_pop(2'd1);
            exp_d = exp_q.pop_front();
            chk("c1_trim_data", 64'(pop_data_r), 64'(exp_d));
        end
        chk("c1_level3", 64'(level_r), 64'h0030);

        // Steady push+pop across pointer wrap
        for (int i = 0; i < 20; i++) begin
            push = 1'b1; push_chan = 2'd1; push_data = 32'h200 + 32'(i);
            pop  = 1'b1; pop_chan  = 2'd1;
            exp_q.push_back(32'h200 + 32'(i));
            tick();
            exp_d = exp_q.pop_front();
            chk("wrap_vld", 64'(pop_vld_r), 64'h1);
            chk("wrap_data", 64'(pop_data_r), 64'(exp_d));
            chk("wrap_level", 64'(level_r), 64'h0030);
        end
        push = 1'b0; pop = 1'b0;
        chk("ovf_sticky", 64'(err_ovf_r), ERR_ON ? 64'b0010 : 64'h0);

        // Mid-stream reset with push held high
        for (int i = 0; i < 5; i++) begin
            do_push(2'd0, 32'h300 + 32'(i));
        end
        chk("pre_rst_level", 64'(level_r), 64'h0035);
        rst = 1'b1; push = 1'b1; push_chan = 2'd0; push_data = 32'h3FF;
        tick();
        rst = 1'b0; push = 1'b0;
        exp_q.delete();
        chk("mrst_level", 64'(level_r), 64'h0);
        chk("mrst_empty", 64'(empty_r), 64'hF);
        chk("mrst_full", 64'(full_r), 64'h0);
        chk("mrst_vld", 64'(pop_vld_r), 64'h0);
        chk("mrst_err", 64'({err_ovf_r, err_udf_r}), 64'h0);
        do_pop(2'd0);
        chk("mrst_pop_vld", 64'(pop_vld_r), 64'h0);
        chk("mrst_pop_level", 64'(level_r), 64'h0);

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
